// File: rtl/seq_detect_param.sv
// Serial pattern detector: shifts accepted bits into a window, flags a registered
// Moore match against a runtime-loadable pattern, and counts matches with saturation.
module seq_detect_param #(
    parameter int                 PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = 4'b1101,
    parameter bit                 OVERLAP = 1'b1,
    parameter int                 CNT_W   = 8,
    localparam int                FW      = $clog2(PAT_LEN + 1)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enable,
    input  logic               seq_in,
    input  logic               load_pat,
    input  logic [PAT_LEN-1:0] pat_in,
    input  logic               clear_cnt,
    output logic               seq_out,
    output logic [CNT_W-1:0]   match_count,
    output logic               cnt_sat,
    output logic [FW-1:0]      fill
);

    localparam logic [FW-1:0]    FILL_FULL = FW'(PAT_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    logic [PAT_LEN-1:0] window_q, window_d;
    logic [PAT_LEN-1:0] pat_q, pat_d;
    logic [FW-1:0]      fill_q, fill_d, fill_inc;
    logic               seq_out_q, seq_out_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sat_q, sat_d;
    logic               accept;
    logic               match;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            window_q  <= '0;
            pat_q     <= PATTERN;
            fill_q    <= '0;
            seq_out_q <= 1'b0;
            cnt_q     <= '0;
            sat_q     <= 1'b0;
        end else begin
            window_q  <= window_d;
            pat_q     <= pat_d;
            fill_q    <= fill_d;
            seq_out_q <= seq_out_d;
            cnt_q     <= cnt_d;
            sat_q     <= sat_d;
        end
    end

    always_comb begin
        window_d  = window_q;
        pat_d     = pat_q;
        fill_d    = fill_q;
        seq_out_d = seq_out_q;
        accept    = enable && !load_pat;
        fill_inc  = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + FW'(1);
        // A match needs a full window; stale bits left behind by a restart never count.
        match     = accept && (fill_inc == FILL_FULL) &&
                    ({window_q[PAT_LEN-2:0], seq_in} == pat_q);

        if (load_pat) begin
            pat_d     = pat_in;
            fill_d    = '0;
            seq_out_d = 1'b0;
        end else if (accept) begin
            window_d  = {window_q[PAT_LEN-2:0], seq_in};
            seq_out_d = match;
            fill_d    = (!OVERLAP && match) ? '0 : fill_inc;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (clear_cnt) begin
            cnt_d = '0;
        end else if (match && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        sat_d = (cnt_d == CNT_MAX);
    end

    assign seq_out     = seq_out_q;
    assign match_count = cnt_q;
    assign cnt_sat     = sat_q;
    assign fill        = fill_q;

endmodule

// File: doc/seq_detect_param.md
SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

Interface
REQ-001 Parameter PAT_LEN, default 4: pattern length in bits; legal range 2..32.
REQ-002 Parameter PATTERN, default 4'b1101 (PAT_LEN bits): reset value of the pattern register; MSB is the first-arrived bit.
REQ-003 Parameter OVERLAP, default 1: 1 = overlapping matches allowed, 0 = window restarts after each match.
REQ-004 Parameter CNT_W, default 8: match counter width; legal range 1..32.
REQ-005 Port clock  input  1  rising-edge clock.
REQ-006 Port reset  input  1  reset, asynchronous, active-high.
REQ-007 Port enable  input  1  seq_in is sampled on this clock edge when high.
REQ-008 Port seq_in  input  1  serial data bit.
REQ-009 Port load_pat  input  1  load pat_in into the pattern register.
REQ-010 Port pat_in  input  PAT_LEN  new pattern; MSB is the first-arrived bit.
REQ-011 Port clear_cnt  input  1  synchronous clear of match_count and cnt_sat.
REQ-012 Port seq_out  output  1  Moore match flag, registered.
REQ-013 Port match_count  output  CNT_W  number of matches, saturating.
REQ-014 Port cnt_sat  output  1  match_count has reached all-ones.
REQ-015 Port fill  output  FW=$clog2(PAT_LEN+1)  accepted bits currently in the window, saturating at PAT_LEN.

Function
REQ-016 An accepted bit is an edge with enable=1 and load_pat=0; the window shifts left and the new bit enters the LSB, so the oldest bit is in the MSB.
REQ-017 On an accepted bit, fill increments and saturates at PAT_LEN.
REQ-018 A match is an accepted bit after which fill==PAT_LEN and the window equals the pattern register in all bits.
REQ-019 seq_out is registered and equals 1 exactly while the post-edge state is a match; zero-latency Moore behaviour means it rises on the edge that accepts the last pattern bit.
REQ-020 With enable=0 and load_pat=0, the window, fill, seq_out and the pattern register all hold their values.
REQ-021 When OVERLAP=1, the window is never cleared by a match, so consecutive overlapping matches each assert seq_out.
REQ-022 When OVERLAP=0, on a match edge seq_out is set to 1 and fill is set to 0. The next accepted bit starts a fresh window with fill=1 and seq_out=0.
REQ-023 load_pat=1 takes priority over enable. On that edge:
  - pat_in is loaded into the pattern register;
  - fill is set to 0 and seq_out to 0;
  - the window contents become don't-care;
  - seq_in is not accepted.
REQ-024 match_count increments by 1 on each match edge and saturates at 2^CNT_W-1. cnt_sat equals (match_count == all-ones), registered.
REQ-025 clear_cnt=1 sets match_count and cnt_sat to 0 on that edge and wins over a simultaneous increment. clear_cnt has no effect on the window, fill or seq_out.
REQ-026 A match can never occur while fill<PAT_LEN, even if the stale window bits equal the pattern.
REQ-027 The block contains no combinational path from any input to any output.

Reset
REQ-028 While reset=1, asynchronously and regardless of clock:
  - seq_out=0, fill=0, match_count=0, cnt_sat=0;
  - the window is all zeros;
  - the pattern register equals PATTERN.
REQ-029 Reset asserted mid-sequence discards all partial progress. After release, a full PAT_LEN accepted bits are required before any match.
REQ-030 A runtime-loaded pattern is lost on reset; the pattern register returns to PATTERN.

Verification (defaults unless stated; one bit per cycle, enable=1)
REQ-031 Overlap: seq_in 1,1,0,1,1,0,1 -> seq_out=1 after bits 4 and 7 only; match_count=2; fill=4 at the end.
REQ-032 OVERLAP=0: same stream -> seq_out=1 after bit 4 only; match_count=1; fill=3 at the end.
REQ-033 Enable gaps: bits 1,1,0 then enable=0 for 5 cycles with seq_in toggling, then bit 1 -> fill stays 3 during the gap; seq_out=1 after the final bit; match_count=1.
REQ-034 Reset mid-operation: bits 1,1,0, then reset for 1 cycle, then bit 1 -> no match, fill=1. Then 1,0,1 -> seq_out=1 after the 4th post-reset bit.
REQ-035 Runtime load: after a match, load_pat=1 with pat_in=4'b0110 and enable=1 -> seq_out=0 and fill=0 on that edge. Stream 0,1,1,0 -> match; stream 1,1,0,1 -> no match.
REQ-036 CNT_W=2 saturation and clear: 4 matches -> match_count=3, cnt_sat=1. Then clear_cnt=1 coincident with a 5th match -> match_count=0, cnt_sat=0, seq_out=1.
